fp32_divider: RTL and testbench
===============================

# fp32_divider

Sequential IEEE 754 single-precision divider. It computes a_i / b_i with an iterative restoring mantissa divider at one quotient bit per cycle. It is the inverse-operation companion to the 32-bit FP multiplier and uses the same start/done handshake and flag set, plus a divide-by-zero flag. It sits beside the multiplier in the FP datapath and is driven by the same controller.

## Interface
Parameters:
- none; the format is fixed at binary32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a new division; sampled only in IDLE.
- a_i  in  32  dividend (binary32); captured on the cycle start_i is accepted.
- b_i  in  32  divisor (binary32); captured with a_i.
- quotient_o  out  32  result; registered; holds its value until the next completion.
- done_o  out  1  single-cycle pulse; quotient_o and the flags are valid on this cycle.
- busy_o  out  1  high from the cycle after acceptance through the DONE cycle.
- nan_o  out  1  NaN operand, or an invalid 0/0 or inf/inf.
- infinit_o  out  1  dividend is infinite (with a finite divisor).
- div_by_zero_o  out  1  finite nonzero dividend divided by zero.
- overflow_o  out  1  result exponent ≥ 255.
- underflow_o  out  1  result exponent ≤ 0, so the result is flushed to zero.

## Operation
- States: IDLE, CHECK, DIVIDE, NORMALIZE, DONE.
- IDLE:
  - On start_i=1, latch a_i and b_i, clear all flags and go to CHECK.
  - start_i is ignored in every other state; operands are never re-sampled mid-operation.
- CHECK: unpack the operands.
  - Subnormal inputs (exponent 0) are treated as zero.
  - The special cases below resolve directly to DONE, in this priority:
    1. Either operand NaN, 0/0, or inf/inf -> 0x7FC00000, nan_o.
    2. inf/finite -> {sign, 0x7F800000}, infinit_o.
    3. Nonzero/0 -> {sign, 0x7F800000}, div_by_zero_o.
    4. 0/x or finite/inf -> {sign, 31'b0}, no flag.
  - Otherwise go to DIVIDE:
    - Load remainder = {1'b0, 1, ma}.
    - Load divisor = {1, mb}.
    - Compute exp = ea − eb + 127 as a 10-bit signed value.
    - Clear the iteration counter.
- DIVIDE: restoring division, 26 iterations, counter 0..25.
  - Each iteration: if rem ≥ div then q bit = 1 and rem −= div, else q bit = 0.
  - Then rem <<= 1 and q shifts left.
  - Exit to NORMALIZE when the counter reaches 25.
- NORMALIZE:
  - If q[25]=0, shift q left by 1 and decrement exp.
  - Mantissa = q[24:2], guard = q[1], sticky = q[0] | (rem ≠ 0).
  - Apply rounding (see Configuration). A rounding carry-out sets the mantissa to 0 and increments exp.
  - exp ≥ 255 -> {sign, 0x7F800000}, overflow_o.
  - exp ≤ 0 -> {sign, 31'b0}, underflow_o.
  - Otherwise pack {sign, exp[7:0], mantissa}.
- DONE:
  - done_o=1 for exactly one cycle, then return to IDLE.
  - quotient_o and all flags hold their values until the next accepted start clears the flags.
- Sign is always a[31] ^ b[31], including for zero and infinity results. A NaN result is always positive.

## Timing
- Reset values: quotient_o=0, done_o=0, busy_o=0, all flags 0, state IDLE.
- Reset asserted mid-operation aborts the division in that cycle; no done_o is produced.
- Cycle numbering: start_i is accepted at edge E0.
  - CHECK occupies cycle 1.
  - DIVIDE occupies cycles 2–27.
  - NORMALIZE occupies cycle 28.
  - DONE occupies cycle 29.
  - Normal latency is therefore 29 cycles (done_o in cycle 29).
- Special-case latency is 2 cycles: CHECK in cycle 1, DONE in cycle 2.
- Back-to-back operation: start_i can be accepted on the first IDLE cycle after DONE. The minimum issue interval is 30 cycles.

## Configuration
- FP32_DIV_ROUND_EN defined: round-to-nearest-even.
  - Increment the mantissa when guard & (sticky | mantissa[0]).
- FP32_DIV_ROUND_EN undefined: truncate (guard and sticky are ignored).
  - This matches the multiplier's behaviour.
- Latency is identical in both builds.

## Structure
- Shared package fp32_pkg holds:
  - the state enum;
  - FP32_QNAN = 0x7FC00000;
  - FP32_INF = 0x7F800000;
  - FP32_BIAS = 127;
  - exponent and mantissa width constants.
- Sub-module fp32_mant_divider: the 26-iteration restoring core.
  - Inputs: load, dividend, divisor.
  - Outputs: q[25:0], remainder-nonzero, last-iteration flag.
  - The top level holds the FSM, the special-case decode and the packing.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, done_o in cycle 29, no flags.
- 0x3F800000 / 0x40400000 (1/3):
  - with FP32_DIV_ROUND_EN -> 0x3EAAAAAB;
  - without it -> 0x3EAAAAAA.
- 0x3F800000 / 0x80000000 -> 0xFF800000, div_by_zero_o=1, done_o in cycle 2.
- 0x7FC00001 / any, and 0x00000000 / 0x00000000 -> 0x7FC00000, nan_o=1.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 with overflow_o.
- 0x00800000 / 0x40000000 -> 0x00000000 with underflow_o.
- Reset and mid-operation behaviour:
  - Assert rst in cycle 15 of a division: outputs are zero, no done_o, and a start two cycles later completes normally.
  - start_i held high throughout: exactly one result per 30 cycles.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared definitions for the binary32 divider datapath.
//   - FSM state enum used by fp32_divider
//   - flag bundle struct (nan / inf / div-by-zero / overflow / underflow)
//   - binary32 constants: quiet NaN, infinity magnitude, exponent bias
//   - field width constants
package fp32_pkg;

    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_BIAS   = 127;
    // Quotient bits produced by the restoring core: 1 integer bit,
    // 23 mantissa bits, guard bit and one extra bit feeding sticky.
    localparam int FP32_Q_W    = 26;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        NORMALIZE,
        DONE
    } state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic dbz;
        logic ovf;
        logic unf;
    } fp32_flags_t;

endpackage

// File: rtl/fp32_mant_divider.sv
// fp32_mant_divider: restoring mantissa divider, one quotient bit per cycle.
// A load captures the operands; the core then runs exactly FP32_Q_W
// iterations on its own and holds the result until the next load.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture dividend/divisor, clear quotient and counter
//   dividend     {1'b0, 1'b1, mantissa_a}
//   divisor      {1'b1, mantissa_b}
//   q            quotient bits, MSB first
//   rem_nonzero  final remainder is nonzero (feeds sticky)
//   last         high during the cycle whose edge performs the final iteration
module fp32_mant_divider
    import fp32_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [FP32_MANT_W+1:0] dividend,
    input  logic [FP32_MANT_W:0]   divisor,
    output logic [FP32_Q_W-1:0]    q,
    output logic                   rem_nonzero,
    output logic                   last
);

    localparam logic [4:0] LAST_CNT = 5'(FP32_Q_W - 1);

    logic [FP32_MANT_W+1:0] rem_reg;
    logic [FP32_MANT_W:0]   div_reg;
    logic [FP32_Q_W-1:0]    q_reg;
    logic [4:0]             cnt_reg;
    logic                   active_reg;

    logic [FP32_MANT_W+1:0] sub;
    logic                   ge;
    logic [FP32_MANT_W+1:0] rem_next;

    // The remainder always stays below twice the divisor (both mantissas
    // carry a hidden one), so the trial subtraction borrows exactly when
    // rem < div and its top bit doubles as the compare result.
    assign sub      = rem_reg - {1'b0, div_reg};
    assign ge       = ~sub[FP32_MANT_W+1];
    assign rem_next = ge ? {sub[FP32_MANT_W:0], 1'b0}
                         : {rem_reg[FP32_MANT_W:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg    <= '0;
            div_reg    <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            rem_reg    <= dividend;
            div_reg    <= divisor;
            q_reg      <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            q_reg   <= {q_reg[FP32_Q_W-2:0], ge};
            rem_reg <= rem_next;
            if (cnt_reg == LAST_CNT) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 5'd1;
            end
        end
    end

    assign q           = q_reg;
    assign rem_nonzero = |rem_reg;
    assign last        = active_reg && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/fp32_divider.sv
// fp32_divider: sequential IEEE 754 binary32 divider (a_i / b_i).
// Subnormal operands are treated as zero; special operands resolve in two
// cycles, normal operands in 29 cycles (CHECK, 26 x DIVIDE, NORMALIZE, DONE).
// Build option: define FP32_DIV_ROUND_EN for round-to-nearest-even;
// otherwise the mantissa is truncated. Latency is the same either way.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start_i        request a division (only honoured in IDLE)
//   a_i, b_i       dividend and divisor, captured on acceptance
//   quotient_o     registered result, held until the next completion
//   done_o         one-cycle completion pulse
//   busy_o         high from the cycle after acceptance through DONE
//   nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o  result flags
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        div_by_zero_o,
    output logic        overflow_o,
    output logic        underflow_o
);

`ifdef FP32_DIV_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    localparam logic signed [9:0] BIAS_S  = 10'(FP32_BIAS);
    localparam logic [7:0]        EXP_MAX = 8'hFF;

    state_t             state_reg, state_next;
    logic [31:0]        a_reg, b_reg;
    logic signed [9:0]  exp_reg;
    logic [31:0]        quotient_reg;
    fp32_flags_t        flags_reg;

    // Operand unpacking, index 0 = dividend, index 1 = divisor.
    logic [31:0]             opnd    [2];
    logic [FP32_EXP_W-1:0]   op_exp  [2];
    logic [FP32_MANT_W-1:0]  op_mant [2];
    logic                    op_zero [2];
    logic                    op_inf  [2];
    logic                    op_nan  [2];

    assign opnd[0] = a_reg;
    assign opnd[1] = b_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_exp[gi]  = opnd[gi][30:23];
            assign op_mant[gi] = opnd[gi][22:0];
            // Exponent 0 covers both true zero and subnormals (flushed).
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (op_exp[gi] == EXP_MAX) && (op_mant[gi] == '0);
            assign op_nan[gi]  = (op_exp[gi] == EXP_MAX) && (op_mant[gi] != '0);
        end
    endgenerate

    logic sign;
    assign sign = a_reg[31] ^ b_reg[31];

    // ---------------------------------------------------------------
    // Special-case decode (evaluated during CHECK)
    // ---------------------------------------------------------------
    logic        special;
    logic [31:0] special_q;
    fp32_flags_t special_flags;

    always_comb begin
        special       = 1'b1;
        special_q     = '0;
        special_flags = '0;
        if (op_nan[0] || op_nan[1] || (op_zero[0] && op_zero[1]) ||
            (op_inf[0] && op_inf[1])) begin
            special_q         = FP32_QNAN;
            special_flags.nan = 1'b1;
        end else if (op_inf[0]) begin
            special_q         = {sign, FP32_INF[30:0]};
            special_flags.inf = 1'b1;
        end else if (op_zero[1]) begin
            special_q         = {sign, FP32_INF[30:0]};
            special_flags.dbz = 1'b1;
        end else if (op_zero[0] || op_inf[1]) begin
            special_q = {sign, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    logic signed [9:0] exp_calc;
    assign exp_calc = $signed({2'b00, op_exp[0]}) - $signed({2'b00, op_exp[1]}) + BIAS_S;

    // ---------------------------------------------------------------
    // Mantissa divider core
    // ---------------------------------------------------------------
    logic                core_load;
    logic [FP32_Q_W-1:0] q;
    logic                rem_nonzero;
    logic                core_last;

    fp32_mant_divider u_mant_divider (
        .clk         (clk),
        .rst         (rst),
        .load        (core_load),
        .dividend    ({1'b0, 1'b1, op_mant[0]}),
        .divisor     ({1'b1, op_mant[1]}),
        .q           (q),
        .rem_nonzero (rem_nonzero),
        .last        (core_last)
    );

    // ---------------------------------------------------------------
    // Normalize, round, range check and pack (evaluated in NORMALIZE)
    // ---------------------------------------------------------------
    logic [FP32_Q_W-2:0] q_norm;
    logic signed [9:0]   exp_norm;
    logic signed [9:0]   exp_final;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [23:0]         mant_sum;
    logic [31:0]         norm_q;
    fp32_flags_t         norm_flags;

    always_comb begin
        // Quotient of two [1,2) mantissas lies in (0.5, 2): at most one
        // left shift brings the leading one to bit 25.
        q_norm   = q[25] ? q[24:0] : {q[23:0], 1'b0};
        exp_norm = q[25] ? exp_reg : exp_reg - 10'sd1;
        guard    = q_norm[1];
        sticky   = q_norm[0] | rem_nonzero;
        round_up = ROUND_EN & guard & (sticky | q_norm[2]);
        // A carry out of the 23-bit mantissa leaves sum[22:0] all zero,
        // which is exactly the rolled-over mantissa.
        mant_sum  = {1'b0, q_norm[24:2]} + {23'd0, round_up};
        exp_final = mant_sum[23] ? exp_norm + 10'sd1 : exp_norm;

        norm_flags = '0;
        norm_q     = {sign, exp_final[7:0], mant_sum[22:0]};
        if (exp_final >= 10'sd255) begin
            norm_q         = {sign, FP32_INF[30:0]};
            norm_flags.ovf = 1'b1;
        end else if (exp_final <= 10'sd0) begin
            norm_q         = {sign, 31'd0};
            norm_flags.unf = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        core_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (special) begin
                    state_next = DONE;
                end else begin
                    state_next = DIVIDE;
                    core_load  = 1'b1;
                end
            end
            DIVIDE: begin
                if (core_last) begin
                    state_next = NORMALIZE;
                end
            end
            NORMALIZE: state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            exp_reg      <= '0;
            quotient_reg <= '0;
            flags_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        a_reg     <= a_i;
                        b_reg     <= b_i;
                        flags_reg <= '0;
                    end
                end
                CHECK: begin
                    exp_reg <= exp_calc;
                    if (special) begin
                        quotient_reg <= special_q;
                        flags_reg    <= special_flags;
                    end
                end
                NORMALIZE: begin
                    quotient_reg <= norm_q;
                    flags_reg    <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign quotient_o    = quotient_reg;
    assign done_o        = (state_reg == DONE);
    assign busy_o        = (state_reg != IDLE);
    assign nan_o         = flags_reg.nan;
    assign infinit_o     = flags_reg.inf;
    assign div_by_zero_o = flags_reg.dbz;
    assign overflow_o    = flags_reg.ovf;
    assign underflow_o   = flags_reg.unf;

endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: scoreboard bench for fp32_divider. Expected results are
// queued when a division is issued and popped when done_o is seen.
// Honours FP32_DIV_ROUND_EN for the inexact reference values.
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] quotient;
    logic        done, busy, nan, infinit, dbz, ovf, unf;
    logic [4:0]  flags;

    fp32_divider dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .a_i           (a_in),
        .b_i           (b_in),
        .quotient_o    (quotient),
        .done_o        (done),
        .busy_o        (busy),
        .nan_o         (nan),
        .infinit_o     (infinit),
        .div_by_zero_o (dbz),
        .overflow_o    (ovf),
        .underflow_o   (unf)
    );

    assign flags = {nan, infinit, dbz, ovf, unf};

    always #5 clk = ~clk;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NAN  = 5'b10000;
    localparam logic [4:0] F_INF  = 5'b01000;
    localparam logic [4:0] F_DBZ  = 5'b00100;
    localparam logic [4:0] F_OVF  = 5'b00010;
    localparam logic [4:0] F_UNF  = 5'b00001;

`ifdef FP32_DIV_ROUND_EN
    localparam logic [31:0] Q_1_3 = 32'h3EAA_AAAB;
    localparam logic [31:0] Q_2_3 = 32'h3F2A_AAAB;
`else
    localparam logic [31:0] Q_1_3 = 32'h3EAA_AAAA;
    localparam logic [31:0] Q_2_3 = 32'h3F2A_AAAA;
`endif

    typedef struct {
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [4:0]  f;
        logic [7:0]  lat;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one start pulse (DUT must be idle) and queue the expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [4:0] ef, input int el);
        exp_t e;
        @(posedge clk); #1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        accept_cyc = cyc;
        e.q = eq;
        e.f = ef;
        e.lat = el;
        sb.push_back(e);
    endtask

    // Wait (bounded) for done_o; latency counts cycle 1 as the cycle after acceptance.
    task automatic collect(output logic [31:0] gq, output logic [4:0] gf,
                           output int glat, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        ok   = (done === 1'b1);
        gq   = quotient;
        gf   = flags;
        glat = cyc - accept_cyc + 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset quotient: got %h, required 00000000", quotient); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, required 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
        checks++; if (flags !== F_NONE) begin errors++; $display("FAIL reset flags: got %b, required %b", flags, F_NONE); end
        rst = 1'b0;
        $display("reset: quotient=%h done=%b busy=%b flags=%b", quotient, done, busy, flags);
    endtask

    // 6/2 with a stray start and new operands mid-operation; checks busy,
    // done pulse width and result hold.
    task automatic test_hold;
        logic [31:0] gq; logic [4:0] gf; int glat; bit ok; exp_t e;
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 29);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold busy cycle1: got %b, required 1", busy); end
        a_in  = 32'h3F80_0000;
        b_in  = 32'h4040_0000;
        start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b0;
        collect(gq, gf, glat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL hold done: got no pulse within bound, required pulse"); end
        checks++; if (gq !== e.q) begin errors++; $display("FAIL hold quotient: got %h, required %h", gq, e.q); end
        checks++; if (gf !== e.f) begin errors++; $display("FAIL hold flags: got %b, required %b", gf, e.f); end
        checks++; if (glat != e.lat) begin errors++; $display("FAIL hold latency: got %0d, required %0d", glat, e.lat); end
        $display("hold: 40c00000/40000000 -> %h flags=%b lat=%0d", gq, gf, glat);
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold done width: got %b, required 0", done); end
        checks++; if (quotient !== 32'h4040_0000) begin errors++; $display("FAIL hold quotient kept: got %h, required 40400000", quotient); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold busy idle: got %b, required 0", busy); end
    endtask

    task automatic test_normal;
        logic [31:0] gq; logic [4:0] gf; int glat; bit ok; exp_t e;
        vec_t tbl [6] = '{
            '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 8'd29},
            '{32'h3F80_0000, 32'h4040_0000, Q_1_3,         F_NONE, 8'd29},
            '{32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, F_NONE, 8'd29},
            '{32'hC100_0000, 32'h4000_0000, 32'hC080_0000, F_NONE, 8'd29},
            '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, F_NONE, 8'd29},
            '{32'h3F80_0000, 32'h3FC0_0000, Q_2_3,         F_NONE, 8'd29}
        };
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].f, int'(tbl[i].lat));
            collect(gq, gf, glat, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL normal[%0d] done: got no pulse within bound, required pulse", i); end
            checks++; if (gq !== e.q) begin errors++; $display("FAIL normal[%0d] quotient: got %h, required %h", i, gq, e.q); end
            checks++; if (gf !== e.f) begin errors++; $display("FAIL normal[%0d] flags: got %b, required %b", i, gf, e.f); end
            checks++; if (glat != e.lat) begin errors++; $display("FAIL normal[%0d] latency: got %0d, required %0d", i, glat, e.lat); end
            $display("normal[%0d]: %h/%h -> %h flags=%b lat=%0d", i, tbl[i].a, tbl[i].b, gq, gf, glat);
        end
    endtask

    // Reset in cycle 15 of a division, then a fresh division.
    task automatic test_mid_reset;
        logic [31:0] gq; logic [4:0] gf; int glat; bit ok; exp_t e;
        @(posedge clk); #1;
        a_in  = 32'h40C0_0000;
        b_in  = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL midreset quotient: got %h, required 00000000", quotient); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset done: got %b, required 0", done); end
        checks++; if (flags !== F_NONE) begin errors++; $display("FAIL midreset flags: got %b, required %b", flags, F_NONE); end
        @(posedge clk); #1;
        issue(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, F_NONE, 29);
        collect(gq, gf, glat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL midreset done after restart: got no pulse, required pulse"); end
        checks++; if (gq !== e.q) begin errors++; $display("FAIL midreset quotient after restart: got %h, required %h", gq, e.q); end
        checks++; if (glat != e.lat) begin errors++; $display("FAIL midreset latency: got %0d, required %0d", glat, e.lat); end
        $display("midreset: restart 3f800000/40000000 -> %h lat=%0d", gq, glat);
    endtask

    task automatic test_special;
        logic [31:0] gq; logic [4:0] gf; int glat; bit ok; exp_t e;
        vec_t tbl [11] = '{
            '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, F_DBZ,  8'd2},
            '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, F_NAN,  8'd2},
            '{32'hBF80_0000, 32'h7FC0_0001, 32'h7FC0_0000, F_NAN,  8'd2},
            '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_NAN,  8'd2},
            '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, F_NAN,  8'd2},
            '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_INF,  8'd2},
            '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, F_INF,  8'd2},
            '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, F_NONE, 8'd2},
            '{32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, F_NONE, 8'd2},
            '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE, 8'd2},
            '{32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, F_DBZ,  8'd2}
        };
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].f, int'(tbl[i].lat));
            collect(gq, gf, glat, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL special[%0d] done: got no pulse within bound, required pulse", i); end
            checks++; if (gq !== e.q) begin errors++; $display("FAIL special[%0d] quotient: got %h, required %h", i, gq, e.q); end
            checks++; if (gf !== e.f) begin errors++; $display("FAIL special[%0d] flags: got %b, required %b", i, gf, e.f); end
            checks++; if (glat != e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d, required %0d", i, glat, e.lat); end
            $display("special[%0d]: %h/%h -> %h flags=%b lat=%0d", i, tbl[i].a, tbl[i].b, gq, gf, glat);
        end
    endtask

    task automatic test_range;
        logic [31:0] gq; logic [4:0] gf; int glat; bit ok; exp_t e;
        vec_t tbl [6] = '{
            '{32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, F_OVF,  8'd29},
            '{32'hFF7F_FFFF, 32'h3F00_0000, 32'hFF80_0000, F_OVF,  8'd29},
            '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF,  8'd29},
            '{32'h8080_0000, 32'h4000_0000, 32'h8000_0000, F_UNF,  8'd29},
            '{32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, F_UNF,  8'd29},
            '{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, F_NONE, 8'd29}
        };
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].f, int'(tbl[i].lat));
            collect(gq, gf, glat, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL range[%0d] done: got no pulse within bound, required pulse", i); end
            checks++; if (gq !== e.q) begin errors++; $display("FAIL range[%0d] quotient: got %h, required %h", i, gq, e.q); end
            checks++; if (gf !== e.f) begin errors++; $display("FAIL range[%0d] flags: got %b, required %b", i, gf, e.f); end
            checks++; if (glat != e.lat) begin errors++; $display("FAIL range[%0d] latency: got %0d, required %0d", i, glat, e.lat); end
            $display("range[%0d]: %h/%h -> %h flags=%b lat=%0d", i, tbl[i].a, tbl[i].b, gq, gf, glat);
        end
    endtask

    // start_i held high: one result every 30 cycles. start drops on the
    // third done so no fourth division is accepted.
    task automatic test_back_to_back;
        int   dones = 0;
        int   done_cyc [3] = '{0, 0, 0};
        logic prev_busy;
        exp_t e;
        @(posedge clk); #1;
        a_in  = 32'h3F80_0000;
        b_in  = 32'h4000_0000;
        start = 1'b1;
        prev_busy = busy;
        for (int n = 0; n < 120; n++) begin
            @(posedge clk); #1;
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                e.q = 32'h3F00_0000;
                e.f = F_NONE;
                e.lat = 29;
                sb.push_back(e);
            end
            prev_busy = busy;
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b unexpected done: got pulse at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++; if (quotient !== e.q) begin errors++; $display("FAIL b2b quotient: got %h, required %h", quotient, e.q); end
                    checks++; if (flags !== e.f) begin errors++; $display("FAIL b2b flags: got %b, required %b", flags, e.f); end
                end
                if (dones < 3) done_cyc[dones] = cyc;
                dones++;
                if (dones == 3) start = 1'b0;
                $display("b2b: done #%0d at cycle %0d quotient=%h", dones, cyc, quotient);
            end
        end
        start = 1'b0;
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b done count: got %0d, required 3", dones); end
        checks++; if (done_cyc[1] - done_cyc[0] != 30) begin errors++; $display("FAIL b2b interval0: got %0d, required 30", done_cyc[1] - done_cyc[0]); end
        checks++; if (done_cyc[2] - done_cyc[1] != 30) begin errors++; $display("FAIL b2b interval1: got %0d, required 30", done_cyc[2] - done_cyc[1]); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b scoreboard drained: got %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_hold;
        test_normal;
        test_mid_reset;
        test_special;
        test_range;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
